// File: rtl/barrel_seq_pkg.sv
// Shared definitions for the barrel-shifter command sequencer: state encoding,
// default data width, rotate direction constants and the width helper.
package barrel_seq_pkg;

  localparam int DATA_SIZE_DEF = 8;

  localparam logic DIR_R = 1'b0;
  localparam logic DIR_L = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ROT  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Ceiling log2; returns the select width needed to address n rotate positions.
  function automatic int log2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Registered rotate-right barrel shifter: Load takes data_in, otherwise it
// rotates its own output; sel = 0 with Load = 0 holds the value.
module barrel_shifter
  import barrel_seq_pkg::*;
#(
  parameter  int DATA_SIZE = DATA_SIZE_DEF,
  localparam int SEL_W     = log2_f(DATA_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Load,
  input  logic [SEL_W-1:0]     sel,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic [DATA_SIZE-1:0] data_out
);

  logic [DATA_SIZE-1:0]   w_src;
  logic [2*DATA_SIZE-1:0] w_dbl;

  // Rotating a doubled copy keeps the wrapped-around bits in the low half.
  assign w_src = Load ? data_in : data_out;
  assign w_dbl = {w_src, w_src} >> sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_out <= '0;
    end else begin
      data_out <= w_dbl[DATA_SIZE-1:0];
    end
  end

endmodule

// File: rtl/barrel_seq.sv
// Command sequencer driving the rotate-right barrel shifter: one load cycle,
// then feedback rotate cycles, result returned over a valid/ready handshake.
module barrel_seq
  import barrel_seq_pkg::*;
#(
  parameter  int DATA_SIZE = DATA_SIZE_DEF,
  parameter  int CNT_W     = 4,
  localparam int SEL_W     = log2_f(DATA_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  input  logic [SEL_W-1:0]     in_amt,
  input  logic                 in_dir,
  input  logic [CNT_W-1:0]     in_count,
  output logic                 brl_load,
  output logic [SEL_W-1:0]     brl_sel,
  output logic [DATA_SIZE-1:0] brl_din,
  input  logic [DATA_SIZE-1:0] brl_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic [SEL_W-1:0]     out_rot,
  output logic                 busy
);

  state_e               r_state;
  state_e               w_state_nxt;
  logic [DATA_SIZE-1:0] r_data;
  logic [SEL_W-1:0]     r_eff;
  logic [CNT_W-1:0]     r_count;
  logic [CNT_W-1:0]     r_rem;
  logic [SEL_W-1:0]     r_rot;

  logic                 w_accept;
  logic [SEL_W-1:0]     w_eff;
  logic [SEL_W-1:0]     w_rot;
  logic                 w_brl_load;
  logic [SEL_W-1:0]     w_brl_sel;
  logic                 w_in_ready;
  logic                 w_out_valid;

  // A left rotate by n is the right rotate by DATA_SIZE - n; left 0 stays 0.
  assign w_eff = (in_dir == DIR_L) ? SEL_W'((DATA_SIZE - int'(in_amt)) % DATA_SIZE)
                                   : in_amt;
  assign w_rot = SEL_W'((int'(w_eff) * int'(in_count)) % DATA_SIZE);

  assign w_accept = (r_state == ST_IDLE) && in_valid;

  // NOTE: every output of this block is given a default before the case so
  // no path leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_brl_load  = 1'b0;
    w_brl_sel   = '0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        w_brl_load  = 1'b1;
        w_brl_sel   = (r_count == '0) ? '0 : r_eff;
        w_state_nxt = (r_count <= CNT_W'(1)) ? ST_DONE : ST_ROT;
      end
      ST_ROT: begin
        w_brl_sel = r_eff;
        if (r_rem == CNT_W'(1)) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in the block.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_eff   <= '0;
      r_count <= '0;
      r_rem   <= '0;
      r_rot   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data  <= in_data;
        r_eff   <= w_eff;
        r_count <= in_count;
        r_rot   <= w_rot;
      end
      if (r_state == ST_LOAD) begin
        r_rem <= r_count - CNT_W'(1);
      end else if (r_state == ST_ROT) begin
        r_rem <= r_rem - CNT_W'(1);
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign brl_load  = w_brl_load;
  assign brl_sel   = w_brl_sel;
  assign brl_din   = r_data;
  assign out_valid = w_out_valid;
  assign out_data  = brl_q;
  assign out_rot   = r_rot;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_barrel_seq.sv
// Bench for barrel_seq driving the real barrel shifter: table vectors, reset
// abort sequence and random commands checked through a result scoreboard.
module tb_barrel_seq;
  import barrel_seq_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic       in_dir;
  logic [3:0] in_count;
  logic       brl_load;
  logic [2:0] brl_sel;
  logic [7:0] brl_din;
  logic [7:0] brl_q;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_rot;
  logic       busy;

  always #5 clk = ~clk;

  barrel_seq #(.DATA_SIZE(8), .CNT_W(4)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_dir(in_dir), .in_count(in_count),
    .brl_load(brl_load), .brl_sel(brl_sel), .brl_din(brl_din), .brl_q(brl_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rot(out_rot), .busy(busy)
  );

  barrel_shifter #(.DATA_SIZE(8)) u_shf (
    .clk(clk), .reset(reset), .Load(brl_load), .sel(brl_sel),
    .data_in(brl_din), .data_out(brl_q)
  );

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic       dir;
    logic [3:0] count;
    logic [7:0] exp_data;
    logic [2:0] exp_rot;
    int         hold;
    int         poke;
  } vec_t;

  typedef struct {
    logic [7:0] din;
    logic [7:0] data;
    logic [2:0] rot;
    logic [2:0] sel;
    logic [3:0] count;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  logic       tr_load [0:39];
  logic [2:0] tr_sel  [0:39];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] eff_f(input logic [2:0] a, input logic dir);
    return dir ? 3'(4'd8 - {1'b0, a}) : a;
  endfunction

  function automatic logic [7:0] rotr_f(input logic [7:0] v, input logic [2:0] n);
    logic [15:0] t;
    t = {v, v} >> n;
    return t[7:0];
  endfunction

  function automatic logic [7:0] model_data(input logic [7:0] d, input logic [2:0] a,
                                            input logic dir, input logic [3:0] c);
    logic [7:0] v;
    v = d;
    for (int i = 0; i < int'(c); i++) v = rotr_f(v, eff_f(a, dir));
    return v;
  endfunction

  function automatic logic [2:0] model_rot(input logic [2:0] a, input logic dir,
                                           input logic [3:0] c);
    return 3'((int'(eff_f(a, dir)) * int'(c)) % 8);
  endfunction

  // Presents one command and returns at the negedge of cycle 1 (the LOAD cycle).
  task automatic issue(input logic [7:0] d, input logic [2:0] a, input logic dir,
                       input logic [3:0] c, input logic [7:0] exp_d, input logic [2:0] exp_r);
    exp_t e;
    @(negedge clk);
    in_data  = d;
    in_amt   = a;
    in_dir   = dir;
    in_count = c;
    in_valid = 1'b1;
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    e.din   = d;
    e.data  = exp_d;
    e.rot   = exp_r;
    e.sel   = eff_f(a, dir);
    e.count = c;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input int hold, input int poke);
    exp_t e;
    int   lat;
    int   exp_lat;
    lat = 1;
    tr_load[1] = brl_load;
    tr_sel[1]  = brl_sel;
    while (!out_valid && lat < 39) begin
      @(negedge clk);
      lat++;
      in_valid = (lat == poke);
      if (lat == poke) begin
        in_data  = 8'hE7;
        in_count = 4'hF;
      end
      tr_load[lat] = brl_load;
      tr_sel[lat]  = brl_sel;
    end
    in_valid = 1'b0;
    check("out_valid_within_budget", 32'(out_valid), 32'd1);
    check("scoreboard_nonempty", 32'(sb_q.size() > 0), 32'd1);
    if (!out_valid || sb_q.size() == 0) begin
      sb_q.delete();
      return;
    end
    e = sb_q.pop_front();
    exp_lat = ((e.count == 4'd0) ? 1 : int'(e.count)) + 1;
    check("latency", 32'(lat), 32'(exp_lat));
    check("out_data", 32'(out_data), 32'(e.data));
    check("out_rot", 32'(out_rot), 32'(e.rot));
    check("brl_din_latched", 32'(brl_din), 32'(e.din));
    check("load_cycle_load", 32'(tr_load[1]), 32'd1);
    check("load_cycle_sel", 32'(tr_sel[1]), (e.count == 4'd0) ? 32'd0 : 32'(e.sel));
    for (int k = 2; k < lat; k++) begin
      check("rot_cycle_load", 32'(tr_load[k]), 32'd0);
      check("rot_cycle_sel", 32'(tr_sel[k]), 32'(e.sel));
    end
    for (int h = 0; h <= hold; h++) begin
      check("done_valid", 32'(out_valid), 32'd1);
      check("done_data_stable", 32'(out_data), 32'(e.data));
      check("done_rot_stable", 32'(out_rot), 32'(e.rot));
      check("done_in_ready", 32'(in_ready), 32'd0);
      check("done_load", 32'(brl_load), 32'd0);
      check("done_sel", 32'(brl_sel), 32'd0);
      if (h < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_after_handshake_busy", 32'(busy), 32'd0);
    check("idle_after_handshake_ready", 32'(in_ready), 32'd1);
    check("idle_after_handshake_valid", 32'(out_valid), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic [2:0] ra;
    logic       rdir;
    logic [3:0] rc;

    vecs[0] = '{8'h81, 3'd1, DIR_R, 4'd1,  8'hC0, 3'd1, 0, 0};
    vecs[1] = '{8'h01, 3'd3, DIR_L, 4'd1,  8'h08, 3'd5, 0, 0};
    vecs[2] = '{8'h01, 3'd2, DIR_R, 4'd3,  8'h04, 3'd6, 0, 0};
    vecs[3] = '{8'hA5, 3'd3, DIR_R, 4'd0,  8'hA5, 3'd0, 0, 0};
    vecs[4] = '{8'hA5, 3'd0, DIR_L, 4'd2,  8'hA5, 3'd0, 0, 0};
    vecs[5] = '{8'h3C, 3'd1, DIR_L, 4'd2,  8'hF0, 3'd6, 5, 0};
    vecs[6] = '{8'h80, 3'd7, DIR_R, 4'd15, 8'h40, 3'd1, 0, 3};
    vecs[7] = '{8'h96, 3'd5, DIR_L, 4'd5,  8'h2D, 3'd7, 2, 0};
    vecs[8] = '{8'h5A, 3'd4, DIR_R, 4'd2,  8'h5A, 3'd0, 0, 0};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_dir    = 1'b0;
    in_count  = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_brl_load", 32'(brl_load), 32'd0);
    check("reset_brl_sel", 32'(brl_sel), 32'd0);
    check("reset_out_rot", 32'(out_rot), 32'd0);
    check("reset_brl_q", 32'(brl_q), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].data, vecs[i].amt, vecs[i].dir, vecs[i].count,
            vecs[i].exp_data, vecs[i].exp_rot);
      wait_result(vecs[i].hold, vecs[i].poke);
    end

    // Abort a count-8 command during ROT; the pending result must be dropped.
    issue(8'hC3, 3'd1, DIR_R, 4'd8, 8'h00, 3'd0);
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_before_reset", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_brl_q", 32'(brl_q), 32'd0);
    check("abort_brl_load", 32'(brl_load), 32'd0);
    reset = 1'b0;
    sb_q.delete();
    issue(8'h12, 3'd3, DIR_L, 4'd2, 8'h84, 3'd2);
    wait_result(0, 0);

    for (int n = 0; n < 16; n++) begin
      rd   = 8'($urandom);
      ra   = 3'($urandom_range(0, 7));
      rdir = 1'($urandom_range(0, 1));
      rc   = 4'($urandom_range(0, 15));
      issue(rd, ra, rdir, rc, model_data(rd, ra, rdir, rc), model_rot(ra, rdir, rc));
      wait_result($urandom_range(0, 2), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/barrel_seq.md
Name: barrel_seq

Overview:
Command sequencer that sits directly upstream of the 8-bit rotate-right barrel shifter and drives its Load/sel inputs. It accepts rotate commands (data, amount, direction, repeat count) over a valid/ready handshake and converts left rotates to the equivalent right rotate. It issues one load cycle followed by feedback rotate cycles, then returns the shifter's registered output over a second valid/ready handshake.

Parameters:
DATA_SIZE, 8, data width; must match the downstream barrel shifter.
SEL_W, log2(DATA_SIZE) = 3, rotate-amount width; derived and never overridden.
CNT_W, 4, width of the repeat count.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  command valid
in_ready  out  1  command accepted when in_valid & in_ready
in_data  in  DATA_SIZE  operand
in_amt  in  SEL_W  rotate amount per step
in_dir  in  1  0 = rotate right, 1 = rotate left
in_count  in  CNT_W  number of rotate steps; 0 = pass-through
brl_load  out  1  to shifter Load
brl_sel  out  SEL_W  to shifter sel
brl_din  out  DATA_SIZE  to shifter data_in
brl_q  in  DATA_SIZE  from shifter data_out (registered)
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid & out_ready
out_data  out  DATA_SIZE  result; equals brl_q while out_valid
out_rot  out  SEL_W  net right-rotation applied, mod DATA_SIZE
busy  out  1  state != IDLE

Behaviour:
- Reset is synchronous and active-high. It forces state to IDLE and clears brl_load, brl_sel, out_valid, out_rot and all internal registers. in_ready is 1 after reset.
- brl_din always carries the latched command data.
- Effective amount: eff = in_amt when in_dir = 0, else (DATA_SIZE - in_amt) mod DATA_SIZE. Left amt 0 gives eff 0.
- States: IDLE, LOAD, ROT, DONE. in_ready = (state == IDLE). Outputs decode from state and registers only; no combinational path from in_* to brl_*.
- IDLE: brl_load = 0, brl_sel = 0, so the shifter holds. On accept, latch data, eff and count, then go to LOAD.
- LOAD: brl_load = 1. brl_sel = eff, or 0 when count = 0.
  - count <= 1: go to DONE.
  - otherwise: set rem = count - 1 and go to ROT.
- ROT: brl_load = 0, brl_sel = eff, rem decrements each cycle. When rem reaches 1 on the current cycle, go to DONE.
- DONE: brl_load = 0, brl_sel = 0 (shifter holds).
  - out_valid = 1, out_data = brl_q.
  - out_rot = (eff * count) mod DATA_SIZE, truncated to SEL_W bits, computed at accept.
  - On out_ready, go to IDLE.
- Latency, accept edge to out_valid high: max(count, 1) + 1 cycles.
- Back-to-back: a new command is accepted no earlier than the cycle after the DONE handshake (one IDLE cycle minimum).
- Backpressure: while out_ready = 0, out_data, out_rot and out_valid stay stable, and the shifter is held via sel = 0 and Load = 0.
- Simultaneous events: in_valid during a non-IDLE state is ignored and not latched.
- Reset mid-operation: abort, go to IDLE next edge, drop any pending result. The shifter shares the reset and clears to 0.
- count = 15 (max): 1 LOAD cycle + 14 ROT cycles; no count overflow.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE = 0, LOAD = 1, ROT = 2, DONE = 3);
  - the DATA_SIZE default;
  - the log2 function used to derive SEL_W;
  - the direction constants DIR_R = 0 and DIR_L = 1.
- No sub-module in barrel_seq itself.
- Testbench top instantiates barrel_seq and the barrel shifter together, with brl_q tied to the shifter's data_out.

Test Plan:
1. Rotate right, single step: data 0x81, amt 1, dir 0, count 1 -> brl_load = 1 with sel 1 in cycle 1; out_valid in cycle 2; out_data 0xC0; out_rot 1.
2. Rotate left: data 0x01, amt 3, dir 1, count 1 -> brl_sel = 5; out_data 0x08; out_rot 5.
3. Repeated steps: data 0x01, amt 2, dir 0, count 3 -> one LOAD then two ROT cycles (load 1, 0, 0; sel 2, 2, 2); out_data 0x04; out_rot 6; out_valid at accept + 4.
4. Pass-through: data 0xA5, count 0 -> sel 0; out_data 0xA5; out_rot 0. Then left amt 0 with count 2 -> out_data 0xA5.
5. Backpressure: hold out_ready = 0 for 5 cycles in DONE -> out_data stable, in_ready = 0, brl_load = 0, brl_sel = 0. Assert out_ready -> IDLE next cycle; second command accepted after that.
6. Reset during ROT (count 8, reset asserted at accept + 3) -> next edge: IDLE, out_valid = 0, in_ready = 1, brl_q = 0x00. A following command completes normally.
